// File: rtl/seq_shifter_if.sv
// Request/response bundle for seq_shifter: operand/mode/amount in, held result out.
// The producer/consumer side uses the master modport; the shifter uses slave.
interface seq_shifter_if #(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned SHW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid,
    input  in_ready,
    output in_data,
    output in_amt,
    output in_mode,
    input  out_valid,
    output out_ready,
    input  out_data
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_data,
    input  in_amt,
    input  in_mode,
    output out_valid,
    input  out_ready,
    output out_data
  );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: latches one request, shifts at most STEP bits per clock, then
// holds the result until the consumer takes it. Modes: LSL, LSR, ASR, ROR.
module seq_shifter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_shifter_if.slave io_bus,
  output logic         busy
);
  localparam int unsigned SHW = $clog2(WIDTH);

  // Step and width held one bit wider than the amount so STEP == WIDTH still fits.
  localparam logic [SHW:0] StepW  = (SHW + 1)'(STEP);
  localparam logic [SHW:0] WidthW = (SHW + 1)'(WIDTH);

  localparam logic [1:0] ModeLsl = 2'b00;
  localparam logic [1:0] ModeLsr = 2'b01;
  localparam logic [1:0] ModeAsr = 2'b10;
  localparam logic [1:0] ModeRor = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StHold
  } state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] w_work_nxt;
  logic [SHW-1:0]   r_rem;
  logic [SHW-1:0]   w_rem_nxt;
  logic [1:0]       r_mode;
  logic [1:0]       w_mode_nxt;

  logic [SHW:0]     w_step;
  logic [WIDTH-1:0] w_shifted;

  // Single step of the latched mode by min(STEP, remaining).
  always_comb begin
    w_step    = ({1'b0, r_rem} > StepW) ? StepW : {1'b0, r_rem};
    w_shifted = r_work;
    unique case (r_mode)
      ModeLsl: w_shifted = r_work << w_step;
      ModeLsr: w_shifted = r_work >> w_step;
      ModeAsr: w_shifted = $signed(r_work) >>> w_step;
      ModeRor: w_shifted = (r_work >> w_step) | (r_work << (WidthW - w_step));
      default: w_shifted = r_work;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_work_nxt  = r_work;
    w_rem_nxt   = r_rem;
    w_mode_nxt  = r_mode;
    unique case (r_state)
      StIdle: begin
        if (io_bus.in_valid) begin
          w_work_nxt  = io_bus.in_data;
          w_rem_nxt   = io_bus.in_amt;
          w_mode_nxt  = io_bus.in_mode;
          w_state_nxt = (io_bus.in_amt != '0) ? StShift : StHold;
        end
      end
      StShift: begin
        w_work_nxt = w_shifted;
        w_rem_nxt  = r_rem - w_step[SHW-1:0];
        if (w_rem_nxt == '0) begin
          w_state_nxt = StHold;
        end
      end
      StHold: begin
        if (io_bus.out_ready) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_work  <= '0;
      r_rem   <= '0;
      r_mode  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_work  <= w_work_nxt;
      r_rem   <= w_rem_nxt;
      r_mode  <= w_mode_nxt;
    end
  end

  always_comb begin
    io_bus.in_ready  = (r_state == StIdle);
    io_bus.out_valid = (r_state == StHold);
    io_bus.out_data  = r_work;
    busy             = (r_state != StIdle);
  end
endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: three instances (STEP 1, 4, 3) driven by directed and random
// requests, checked against a plain-arithmetic shift model and ceil(amt/STEP) latency.
module tb_seq_shifter;
  localparam int W    = 32;
  localparam int NDUT = 3;
  localparam int STEPS [NDUT] = '{1, 4, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        c_valid [NDUT];
  logic [31:0] c_data  [NDUT];
  logic [4:0]  c_amt   [NDUT];
  logic [1:0]  c_mode  [NDUT];
  logic        c_ready [NDUT];
  logic        w_in_ready  [NDUT];
  logic        w_out_valid [NDUT];
  logic [31:0] w_out_data  [NDUT];
  logic        w_busy      [NDUT];

  int checks   = 0;
  int failures = 0;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    seq_shifter_if #(.WIDTH(W)) u_if ();
    assign u_if.in_valid   = c_valid[g];
    assign u_if.in_data    = c_data[g];
    assign u_if.in_amt     = c_amt[g];
    assign u_if.in_mode    = c_mode[g];
    assign u_if.out_ready  = c_ready[g];
    assign w_in_ready[g]   = u_if.in_ready;
    assign w_out_valid[g]  = u_if.out_valid;
    assign w_out_data[g]   = u_if.out_data;
    seq_shifter #(.WIDTH(W), .STEP(STEPS[g])) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io_bus(u_if.slave),
      .busy  (w_busy[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Whole-word reference: one shift by the full amount.
  function automatic logic [31:0] model(input logic [31:0] d, input int a, input logic [1:0] m);
    logic [63:0] t;
    case (m)
      2'd0:    return d << a;
      2'd1:    return d >> a;
      2'd2:    begin t = {{32{d[31]}}, d} >> a; return t[31:0]; end
      default: begin t = {d, d} >> a; return t[31:0]; end
    endcase
  endfunction

  task automatic do_op(input int s, input logic [31:0] d, input int a, input logic [1:0] m,
                       input int hold);
    logic [31:0] exp;
    int          lat;
    int          n;
    logic        ok;
    exp = model(d, a, m);
    lat = (a + STEPS[s] - 1) / STEPS[s];
    n = 0;
    while (w_in_ready[s] !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk($sformatf("d%0d_ready_before", s), 32'(w_in_ready[s]), 32'd1);
    c_valid[s] = 1'b1;
    c_data[s]  = d;
    c_amt[s]   = 5'(a);
    c_mode[s]  = m;
    step();
    c_valid[s] = 1'b0;
    n  = 0;
    ok = 1'b1;
    // Noise on the inputs while busy must not disturb the latched request.
    while (w_out_valid[s] !== 1'b1 && n < 100) begin
      if (w_busy[s] !== 1'b1 || w_in_ready[s] !== 1'b0) ok = 1'b0;
      c_valid[s] = 1'($urandom_range(0, 1));
      c_data[s]  = $urandom;
      c_amt[s]   = 5'($urandom_range(0, 31));
      c_mode[s]  = 2'($urandom_range(0, 3));
      c_ready[s] = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    c_valid[s] = 1'b0;
    c_ready[s] = 1'b0;
    chk($sformatf("d%0d_latency_amt%0d", s, a), 32'(n), 32'(lat));
    if (lat > 0) chk($sformatf("d%0d_busy_in_shift", s), 32'(ok), 32'd1);
    chk($sformatf("d%0d_data_m%0d_a%0d", s, m, a), w_out_data[s], exp);
    if (hold > 0) begin
      ok = 1'b1;
      repeat (hold) begin
        step();
        if (w_out_valid[s] !== 1'b1 || w_out_data[s] !== exp || w_in_ready[s] !== 1'b0 ||
            w_busy[s] !== 1'b1) ok = 1'b0;
      end
      chk($sformatf("d%0d_hold_stable", s), 32'(ok), 32'd1);
    end
    c_ready[s] = 1'b1;
    step();
    c_ready[s] = 1'b0;
    chk($sformatf("d%0d_release_valid", s), 32'(w_out_valid[s]), 32'd0);
    chk($sformatf("d%0d_release_ready", s), 32'(w_in_ready[s]), 32'd1);
  endtask

  task automatic chk_reset(input int s, input string tag);
    chk($sformatf("%s_d%0d_in_ready", tag, s), 32'(w_in_ready[s]), 32'd1);
    chk($sformatf("%s_d%0d_out_valid", tag, s), 32'(w_out_valid[s]), 32'd0);
    chk($sformatf("%s_d%0d_busy", tag, s), 32'(w_busy[s]), 32'd0);
    chk($sformatf("%s_d%0d_out_data", tag, s), w_out_data[s], 32'd0);
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      c_valid[i] = 1'b0;
      c_data[i]  = '0;
      c_amt[i]   = '0;
      c_mode[i]  = '0;
      c_ready[i] = 1'b0;
    end
    repeat (2) step();
    for (int i = 0; i < NDUT; i++) chk_reset(i, "reset");
    rst_n = 1'b1;
    step();
    chk_reset(0, "post_reset");

    do_op(0, 32'h0000_0007, 1, 2'd0, 0);
    do_op(0, 32'h0000_0003, 1, 2'd1, 0);
    do_op(1, 32'h8000_0000, 4, 2'd2, 0);
    do_op(1, 32'h8000_0000, 0, 2'd2, 0);
    do_op(1, 32'h0000_0001, 5, 2'd3, 0);
    do_op(0, 32'hFFFF_FFFF, 31, 2'd1, 0);
    do_op(0, 32'h8421_00F5, 7, 2'd2, 5);
    do_op(2, 32'h8000_0001, 31, 2'd3, 2);
    do_op(2, 32'hC000_0000, 8, 2'd2, 0);

    // Reset in the middle of a 20-bit LSL on the STEP=1 instance.
    c_valid[0] = 1'b1;
    c_data[0]  = 32'h0000_0ABC;
    c_amt[0]   = 5'd20;
    c_mode[0]  = 2'd0;
    step();
    c_valid[0] = 1'b0;
    repeat (10) step();
    rst_n = 1'b0;
    #1;
    chk_reset(0, "mid_reset");
    seen = 1'b0;
    repeat (3) begin
      step();
      seen |= w_out_valid[0];
    end
    rst_n = 1'b1;
    repeat (25) begin
      step();
      seen |= w_out_valid[0];
    end
    chk("mid_reset_no_valid", 32'(seen), 32'd0);
    chk("mid_reset_ready", 32'(w_in_ready[0]), 32'd1);
    do_op(0, 32'h0000_0ABC, 20, 2'd0, 0);

    for (int k = 0; k < 25; k++) begin
      for (int s = 0; s < NDUT; s++) begin
        do_op(s, $urandom, int'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
